// File: rtl/muldiv_stall_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_stall_ctrl
//
// Pipeline stall controller for a multi-cycle multiplier / iterative divider.
// It issues a one-cycle start pulse when a mul/div instruction reaches EX,
// counts down the unit latency, freezes the front of the pipeline and the
// EX/MEM register while the unit works, and releases EX/MEM in the single
// DONE cycle so hi/lo are captured. It also folds the load-use hazard into
// the front-end stall and counts stalled cycles (saturating).
//
// Parameters
//   MUL_LAT      multiplier latency in cycles (1..31)
//   DIV_LAT      divider latency in cycles (1..63)
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-low reset
//   ex_valid     EX stage holds a valid instruction
//   ex_op[2:0]   001 mult, 010 multu, 011 div, 100 divu, anything else = none
//   lu_hazard    load-use hazard detected in ID
//   flush        pipeline flush; aborts any mul/div in flight
//   md_start     one-cycle start pulse to the mul/div unit
//   md_signed    signed operation, valid with md_start
//   md_is_div    1 = divider, 0 = multiplier, valid with md_start
//   md_abort     one-cycle abort pulse to the mul/div unit
//   md_busy      operation in flight (MUL or DIV state)
//   stall_front  freeze PC, IF/ID and ID/EX
//   id_ex_bubble zero the control bits of ID/EX
//   ex_mem_ena   EX/MEM register enable
//   md_done      result valid; EX/MEM captures hi/lo this cycle
//   stall_cnt    number of cycles with stall_front=1, saturating
// -----------------------------------------------------------------------------
module muldiv_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic        lu_hazard,
  input  logic        flush,
  output logic        md_start,
  output logic        md_signed,
  output logic        md_is_div,
  output logic        md_abort,
  output logic        md_busy,
  output logic        stall_front,
  output logic        id_ex_bubble,
  output logic        ex_mem_ena,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The counter is loaded with LAT-1 in the start cycle; the busy state is
  // left when the decremented value would reach zero, so md_done lands
  // exactly LAT cycles after md_start.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [31:0] stall_cnt_reg;

  logic op_mul, op_div, op_signed;
  logic start, busy, abort, md_stall, not_done;

  assign op_mul    = (ex_op == 3'b001) || (ex_op == 3'b010);
  assign op_div    = (ex_op == 3'b011) || (ex_op == 3'b100);
  assign op_signed = (ex_op == 3'b001) || (ex_op == 3'b011);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    start        = 1'b0;
    busy         = 1'b0;
    abort        = 1'b0;
    md_stall     = 1'b0;
    not_done     = 1'b1;
    md_start     = 1'b0;
    md_signed    = 1'b0;
    md_is_div    = 1'b0;
    md_abort     = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    stall_front  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_ena   = 1'b1;

    start    = ex_valid && (op_mul || op_div) && (state_reg == IDLE) && !flush;
    busy     = (state_reg == MUL) || (state_reg == DIV);
    abort    = busy && flush;
    not_done = (state_reg != DONE);
    // A flush during an operation drops the mul/div stall in that same cycle.
    md_stall = start || (busy && !flush);

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (op_div) begin
            cnt_next   = DIV_LOAD;
            state_next = (DIV_LOAD == 6'd0) ? DONE : DIV;
          end else begin
            cnt_next   = MUL_LOAD;
            state_next = (MUL_LOAD == 6'd0) ? DONE : MUL;
          end
        end
      end
      MUL, DIV: begin
        if (flush) begin
          cnt_next   = 6'd0;
          state_next = IDLE;
        end else if (cnt_reg <= 6'd1) begin
          cnt_next   = 6'd0;
          state_next = DONE;
        end else begin
          cnt_next   = cnt_reg - 6'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 6'd0;
      end
    endcase

    md_start     = start;
    md_signed    = start && op_signed;
    md_is_div    = start && op_div;
    md_abort     = abort;
    md_busy      = busy;
    md_done      = (state_reg == DONE);
    ex_mem_ena   = !md_stall;
    // Load-use is ignored in DONE: the instruction behind the mul/div is
    // re-evaluated once the pipeline moves again. An abort cycle releases
    // every stall so the flush can propagate.
    stall_front  = md_stall || (lu_hazard && not_done && !abort);
    id_ex_bubble = lu_hazard && !md_stall && not_done && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= 32'd0;
    end else if (stall_front && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_stall_ctrl
//
// Directed bench for muldiv_stall_ctrl with default latencies. Inputs are
// driven on the falling edge, outputs sampled 1 ns later. Each md_start
// pushes its expected md_done cycle into a scoreboard queue; md_done pops
// and compares the cycle, md_abort pops silently, and an overdue entry or a
// done with an empty queue is reported.
// -----------------------------------------------------------------------------
module tb_muldiv_stall_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_op = 3'b000;
  logic        lu_hazard = 1'b0;
  logic        flush = 1'b0;
  logic        md_start, md_signed, md_is_div, md_abort, md_busy;
  logic        stall_front, id_ex_bubble, ex_mem_ena, md_done;
  logic [31:0] stall_cnt;

  int cyc = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int sb[$];

  muldiv_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .lu_hazard    (lu_hazard),
    .flush        (flush),
    .md_start     (md_start),
    .md_signed    (md_signed),
    .md_is_div    (md_is_div),
    .md_abort     (md_abort),
    .md_busy      (md_busy),
    .stall_front  (stall_front),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_ena   (ex_mem_ena),
    .md_done      (md_done),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic monitor();
    int e;
    if (rst) begin
      if (md_start) begin
        sb.push_back(cyc + (md_is_div ? DIV_LAT : MUL_LAT));
        $display("cycle %0d: start is_div=%0b signed=%0b", cyc, md_is_div, md_signed);
      end
      if (md_abort) begin
        if (sb.size() == 0) chk("abort_unexpected", {31'd0, md_abort}, 32'd0);
        else begin
          e = sb.pop_front();
          $display("cycle %0d: abort (was due at %0d)", cyc, e);
        end
      end
      if (md_done) begin
        if (sb.size() == 0) chk("done_unexpected", {31'd0, md_done}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e);
          $display("cycle %0d: done (expected %0d)", cyc, e);
        end
      end else if (sb.size() > 0 && cyc > sb[0]) begin
        chk("done_timeout", cyc, sb[0]);
        e = sb.pop_front();
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] op,
                      input logic lu, input logic fl);
    @(negedge clk);
    rst = r; ex_valid = v; ex_op = op; lu_hazard = lu; flush = fl;
    #1;
    monitor();
  endtask

  initial begin
    int base;
    int n;

    // Reset
    repeat (3) step(0, 0, 3'b000, 0, 0);
    step(1, 0, 3'b000, 0, 0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);
    chk("rst_abort", {31'd0, md_abort}, 32'd0);
    chk("rst_stall_front", {31'd0, stall_front}, 32'd0);
    chk("rst_ex_mem_ena", {31'd0, ex_mem_ena}, 32'd1);
    chk("rst_bubble", {31'd0, id_ex_bubble}, 32'd0);

    // mult, ex_valid held through DONE: DONE must not restart
    base = stall_cnt;
    step(1, 1, 3'b001, 0, 0);
    chk("mult_start", {31'd0, md_start}, 32'd1);
    chk("mult_signed", {31'd0, md_signed}, 32'd1);
    chk("mult_is_div", {31'd0, md_is_div}, 32'd0);
    chk("mult_c0_ena", {31'd0, ex_mem_ena}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 3'b001, 0, 0);
      chk("mult_busy_ena", {31'd0, ex_mem_ena}, 32'd0);
      chk("mult_busy", {31'd0, md_busy}, 32'd1);
      chk("mult_no_restart", {31'd0, md_start}, 32'd0);
    end
    step(1, 1, 3'b001, 0, 0);
    chk("mult_done", {31'd0, md_done}, 32'd1);
    chk("mult_done_ena", {31'd0, ex_mem_ena}, 32'd1);
    chk("mult_done_no_start", {31'd0, md_start}, 32'd0);
    step(1, 0, 3'b000, 0, 0);
    chk("mult_idle_busy", {31'd0, md_busy}, 32'd0);
    chk("mult_idle_done", {31'd0, md_done}, 32'd0);
    chk("mult_stall_cnt", stall_cnt - base, 32'd4);

    // divu
    base = stall_cnt;
    step(1, 1, 3'b100, 0, 0);
    chk("divu_start", {31'd0, md_start}, 32'd1);
    chk("divu_is_div", {31'd0, md_is_div}, 32'd1);
    chk("divu_signed", {31'd0, md_signed}, 32'd0);
    n = 0;
    for (int i = 1; i <= 31; i++) begin
      step(1, 0, 3'b000, 0, 0);
      if (stall_front) n++;
    end
    chk("divu_stall_cycles", n, 32'd31);
    step(1, 0, 3'b000, 0, 0);
    chk("divu_done", {31'd0, md_done}, 32'd1);
    chk("divu_done_stall", {31'd0, stall_front}, 32'd0);
    step(1, 0, 3'b000, 0, 0);
    chk("divu_stall_cnt", stall_cnt - base, 32'd32);

    // div aborted by flush at c10
    step(1, 1, 3'b011, 0, 0);
    chk("div_signed", {31'd0, md_signed}, 32'd1);
    chk("div_is_div", {31'd0, md_is_div}, 32'd1);
    repeat (9) step(1, 0, 3'b000, 0, 0);
    step(1, 0, 3'b000, 0, 1);
    chk("flush_abort", {31'd0, md_abort}, 32'd1);
    chk("flush_stall_front", {31'd0, stall_front}, 32'd0);
    chk("flush_ex_mem_ena", {31'd0, ex_mem_ena}, 32'd1);
    step(1, 0, 3'b000, 0, 0);
    chk("flush_idle_busy", {31'd0, md_busy}, 32'd0);
    chk("flush_abort_once", {31'd0, md_abort}, 32'd0);
    repeat (35) step(1, 0, 3'b000, 0, 0);
    chk("flush_sb_empty", sb.size(), 32'd0);

    // flush in IDLE suppresses start and bubble, no abort
    step(1, 1, 3'b001, 1, 1);
    chk("idle_flush_start", {31'd0, md_start}, 32'd0);
    chk("idle_flush_abort", {31'd0, md_abort}, 32'd0);
    chk("idle_flush_bubble", {31'd0, id_ex_bubble}, 32'd0);
    step(1, 0, 3'b000, 0, 0);
    chk("idle_flush_busy", {31'd0, md_busy}, 32'd0);

    // load-use for two cycles in IDLE
    base = stall_cnt;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 3'b000, 1, 0);
      chk("lu_stall_front", {31'd0, stall_front}, 32'd1);
      chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
      chk("lu_ex_mem_ena", {31'd0, ex_mem_ena}, 32'd1);
    end
    step(1, 0, 3'b000, 0, 0);
    chk("lu_stall_cnt", stall_cnt - base, 32'd2);

    // load-use during multu, flush arriving in DONE
    step(1, 1, 3'b010, 1, 0);
    chk("lumul_bubble_c0", {31'd0, id_ex_bubble}, 32'd0);
    chk("lumul_stall_c0", {31'd0, stall_front}, 32'd1);
    chk("lumul_signed", {31'd0, md_signed}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 3'b000, 1, 0);
      chk("lumul_bubble", {31'd0, id_ex_bubble}, 32'd0);
    end
    step(1, 0, 3'b000, 1, 1);
    chk("done_flush_done", {31'd0, md_done}, 32'd1);
    chk("done_flush_abort", {31'd0, md_abort}, 32'd0);
    chk("done_lu_bubble", {31'd0, id_ex_bubble}, 32'd0);
    step(1, 0, 3'b000, 1, 0);
    chk("after_done_bubble", {31'd0, id_ex_bubble}, 32'd1);
    chk("after_done_stall", {31'd0, stall_front}, 32'd1);
    step(1, 0, 3'b000, 0, 0);

    // reset at c2 of a div
    step(1, 1, 3'b011, 0, 0);
    step(1, 0, 3'b000, 0, 0);
    step(0, 0, 3'b000, 0, 0);
    sb.delete();
    step(1, 0, 3'b000, 0, 0);
    chk("midrst_busy", {31'd0, md_busy}, 32'd0);
    chk("midrst_done", {31'd0, md_done}, 32'd0);
    chk("midrst_stall_cnt", stall_cnt, 32'd0);
    repeat (40) step(1, 0, 3'b000, 0, 0);
    chk("midrst_sb_empty", sb.size(), 32'd0);

    // saturation
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    step(1, 0, 3'b000, 0, 0);
    chk("sat_preload", stall_cnt, 32'hFFFF_FFFE);
    release dut.stall_cnt_reg;
    step(1, 0, 3'b000, 1, 0);
    step(1, 0, 3'b000, 1, 0);
    chk("sat_reach", stall_cnt, 32'hFFFF_FFFF);
    step(1, 0, 3'b000, 1, 0);
    step(1, 0, 3'b000, 0, 0);
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
